// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver with a one-byte holding register, read by the CPU
// through memory-mapped DATA (BASE_ADDR) and STATUS (BASE_ADDR+4) words.
module uart_rx_mmio #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        serial,
  input  logic [31:0] A,
  input  logic        RE,
  output logic [31:0] RD,
  output logic        rx_valid
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [31:0]   STAT_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;
  logic          frameErr_q, frameErr_d;
  logic          sRx;
  logic          byteDone, frameSet;
  logic          dataRd, statusRd;

  assign sRx = sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (!sRx) state_d = ST_START;
      ST_START: if (cnt_q == HALF_LAST) state_d = sRx ? ST_IDLE : ST_DATA;
      ST_DATA:  if (cnt_q == BIT_LAST && bitIdx_q == 3'd7) state_d = ST_STOP;
      ST_STOP:  if (cnt_q == BIT_LAST) state_d = sRx ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (sRx) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Counters restart at every sampling point so each sample lands mid-bit.
  always_comb begin
    cnt_d    = cnt_q + CW'(1);
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    byteDone = 1'b0;
    frameSet = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d    = '0;
        bitIdx_d = 3'd0;
      end
      ST_START: if (cnt_q == HALF_LAST) begin
        cnt_d    = '0;
        bitIdx_d = 3'd0;
      end
      ST_DATA: if (cnt_q == BIT_LAST) begin
        cnt_d    = '0;
        bitIdx_d = bitIdx_q + 3'd1;
        shift_d  = {sRx, shift_q[7:1]};
      end
      ST_STOP: if (cnt_q == BIT_LAST) begin
        cnt_d    = '0;
        byteDone = sRx;
        frameSet = !sRx;
      end
      ST_BREAK: cnt_d = '0;
      default:  cnt_d = '0;
    endcase
  end

  assign dataRd   = RE && (A == BASE_ADDR);
  assign statusRd = RE && (A == STAT_ADDR);

  // New-byte and error sets take priority over the read-triggered clears.
  always_comb begin
    data_d     = byteDone ? shift_q : data_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    frameErr_d = frameErr_q;
    if (byteDone)    valid_d = 1'b1;
    else if (dataRd) valid_d = 1'b0;
    if (byteDone && valid_q && !dataRd) overrun_d = 1'b1;
    else if (statusRd)                  overrun_d = 1'b0;
    if (frameSet)      frameErr_d = 1'b1;
    else if (statusRd) frameErr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      cnt_q      <= '0;
      bitIdx_q   <= 3'd0;
      shift_q    <= 8'h00;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      sync1_q    <= serial;
      sync2_q    <= sync1_q;
      cnt_q      <= cnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      frameErr_q <= frameErr_d;
    end
  end

  always_comb begin
    RD = 32'h0;
    if (A == BASE_ADDR)      RD = {24'h0, data_q};
    else if (A == STAT_ADDR) RD = {29'h0, overrun_q, frameErr_q, valid_q};
  end

  assign rx_valid = valid_q;

endmodule
